alu_exec_sequencer: RTL and testbench
=====================================

// Module: alu_exec_sequencer
// PURPOSE
//  Multi-cycle execute controller that sits directly upstream of the 8-bit ALU.
//  - Accepts one 16-bit instruction per handshake.
//  - Reads operands from a 4-entry register file and drives the ALU inputs.
//  - Captures the ALU result and carry, then writes back and updates flags.
//  - Forms the sequencing core of the CPU datapath between instruction fetch and the ALU.
// PARAMETERS
//  DATA_W   8   datapath width; must equal the ALU operand width
//  IMM_W    7   immediate field width; zero-extended to DATA_W
//  NREGS    4   register file depth; fixed by the 2-bit rd/rs fields
// PORTS
//  clk          in   1       rising-edge clock
//  rst_n        in   1       synchronous active-low reset
//  instr_valid  in   1       instruction available
//  instr_ready  out  1       sequencer can accept an instruction
//  instr        in   16      [15:12] alu_sel, [11:10] rd, [9:8] rs, [7] imm_en, [6:0] imm
//  alu_a        out  DATA_W  ALU operand A (registered)
//  alu_b        out  DATA_W  ALU operand B (registered)
//  alu_sel      out  4       ALU opcode (registered)
//  alu_out      in   DATA_W  ALU result
//  alu_carry    in   1       ALU carry out
//  result_valid out  1       1-cycle pulse on writeback
//  result_rd    out  2       destination register written
//  result_data  out  DATA_W  value written
//  flag_zero    out  1       last written value == 0
//  flag_carry   out  1       carry from the last ADD (sel 4'b0000)
//  busy         out  1       high in any state other than IDLE
// BEHAVIOUR
//  - Reset (rst_n=0 at an edge, any state):
//    - FSM goes to IDLE; regfile[0..3] = 0.
//    - alu_a, alu_b, alu_sel, result_* and flags = 0; instr_ready = 1 the next cycle.
//  - FSM: IDLE -> DECODE -> EXEC -> WB -> IDLE; one instruction per 4 cycles.
//  - IDLE:
//    - instr_ready = 1.
//    - On instr_valid & instr_ready, latch instr and go to DECODE.
//  - DECODE:
//    - alu_a <= reg[rd]; alu_sel <= instr[15:12].
//    - alu_b <= imm_en ? {0, imm} : reg[rs].
//  - EXEC: sample alu_out and alu_carry into holding registers.
//  - WB:
//    - reg[rd] <= held result; result_valid = 1; result_rd and result_data hold the written value.
//    - flag_zero <= (result == 0).
//    - flag_carry updates only when alu_sel == 0000, otherwise it holds.
//  - Latency: handshake edge N -> result_valid high in cycle N+3 -> instr_ready high again in cycle N+4.
//  - instr_ready = 0 in DECODE, EXEC and WB. instr_valid during that time is ignored; instr is not consumed.
//  - rd == rs is legal: both operands read the same pre-write value.
//  - result_valid is low in every state except WB. alu_a, alu_b and alu_sel hold their values until the next DECODE.
// CONFIGURATION
//  `DIV_ZERO_TRAP_EN
//   - Defined: if alu_sel == 0011 and alu_b == 0 in EXEC, WB skips the regfile write.
//     - result_valid still pulses with result_data = 8'hFF.
//     - Output div_err (1 bit) is set and stays set until reset.
//     - Flags hold.
//   - Undefined: no div_err port; the ALU output is written back unchanged.
// STRUCTURE
//  Shared package cpu_pkg:
//   - state enum {IDLE, DECODE, EXEC, WB}
//   - opcode localparams OP_ADD=4'b0000, OP_DIV=4'b0011
//   - instruction field slices
//  Sub-module regfile_4x8: 2 async read ports, 1 sync write port, synchronous active-low clear.
// TESTING
//  - Reset: hold rst_n=0 for 2 cycles -> all outputs 0, instr_ready=1, all regs read 0.
//  - Immediate add: instr=16'h0085 (ADD r0, imm 5), ALU model attached.
//    - result_valid in cycle N+3, rd=0, data=5, flag_zero=0.
//  - Register add with carry: with r1=200, r2=100, instr ADD r1,r2.
//    - data=44, flag_carry=1.
//    - A following XOR r1,r1 gives data=0, flag_zero=1, flag_carry still 1.
//  - Back-pressure: instr_valid held high through 3 instructions.
//    - Exactly 3 result_valid pulses, spaced 4 cycles apart; no instruction lost or duplicated.
//  - Reset mid-op: rst_n=0 during EXEC.
//    - No result_valid pulse; target register reads 0; FSM in IDLE next cycle.
//  - Divide by zero, DIV r0,imm 0 with r0=9:
//    - TRAP_EN defined: r0 stays 9, div_err=1, data=FF.
//    - TRAP_EN undefined: writeback occurs.

Source files
------------

// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the execute sequencer: datapath widths, FSM state
// encoding, the opcodes the sequencer treats specially, and helpers that
// slice the 16-bit instruction word into its fields.
//   instr[15:12] alu_sel, [11:10] rd, [9:8] rs, [7] imm_en, [6:0] imm
// -----------------------------------------------------------------------------
package cpu_pkg;

    localparam int DATA_W  = 8;
    localparam int IMM_W   = 7;
    localparam int NREGS   = 4;
    localparam int RADDR_W = 2;
    localparam int INSTR_W = 16;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_DIV = 4'b0011;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        EXEC   = 2'd2,
        WB     = 2'd3
    } state_e;

    function automatic logic [3:0] f_sel(input logic [INSTR_W-1:0] ins);
        return ins[15:12];
    endfunction

    function automatic logic [RADDR_W-1:0] f_rd(input logic [INSTR_W-1:0] ins);
        return ins[11:10];
    endfunction

    function automatic logic [RADDR_W-1:0] f_rs(input logic [INSTR_W-1:0] ins);
        return ins[9:8];
    endfunction

    function automatic logic f_imm_en(input logic [INSTR_W-1:0] ins);
        return ins[7];
    endfunction

    // Immediate is unsigned: zero-extend to the datapath width.
    function automatic logic [DATA_W-1:0] f_imm_zext(input logic [INSTR_W-1:0] ins);
        return {{(DATA_W-IMM_W){1'b0}}, ins[IMM_W-1:0]};
    endfunction

endpackage

// File: rtl/alu_exec_sequencer_if.sv
// -----------------------------------------------------------------------------
// alu_exec_sequencer_if
// Instruction handshake between the fetch stage and the execute sequencer.
//   instr_valid  fetch -> sequencer  instruction available
//   instr_ready  sequencer -> fetch  sequencer can accept an instruction
//   instr        fetch -> sequencer  16-bit instruction word
// master: fetch side.  slave: sequencer side.
// -----------------------------------------------------------------------------
interface alu_exec_sequencer_if;
    import cpu_pkg::*;

    logic               instr_valid;
    logic               instr_ready;
    logic [INSTR_W-1:0] instr;

    modport master (output instr_valid, output instr, input instr_ready);
    modport slave  (input instr_valid, input instr, output instr_ready);

endinterface

// File: rtl/regfile_4x8.sv
// -----------------------------------------------------------------------------
// regfile_4x8
// Four 8-bit registers, two asynchronous read ports, one synchronous write
// port, cleared by the synchronous active-low reset.
//   clk, rst_n          clock / synchronous active-low clear
//   we, waddr, wdata    write port
//   raddr_a, rdata_a    read port A (combinational)
//   raddr_b, rdata_b    read port B (combinational)
// -----------------------------------------------------------------------------
module regfile_4x8
    import cpu_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               we,
    input  logic [RADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0]  wdata,
    input  logic [RADDR_W-1:0] raddr_a,
    output logic [DATA_W-1:0]  rdata_a,
    input  logic [RADDR_W-1:0] raddr_b,
    output logic [DATA_W-1:0]  rdata_b
);

    logic [DATA_W-1:0] mem_q [NREGS];

    // Register storage: clear on reset, otherwise single write port.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                mem_q[i] <= {DATA_W{1'b0}};
            end
        end else if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata_a = mem_q[raddr_a];
    assign rdata_b = mem_q[raddr_b];

endmodule

// File: rtl/alu_exec_sequencer.sv
// -----------------------------------------------------------------------------
// alu_exec_sequencer
// Multi-cycle execute controller in front of the 8-bit ALU. One instruction
// per four cycles: IDLE (accept) -> DECODE (drive ALU operands) -> EXEC
// (capture ALU result) -> WB (write back, pulse result_valid, update flags).
// Ports:
//   clk, rst_n        clock / synchronous active-low reset
//   instr_if (slave)  instr_valid / instr_ready / instr handshake
//   alu_a/b/sel       registered ALU operands and opcode
//   alu_out/carry     ALU result inputs
//   result_valid/rd/data  writeback report, valid only during WB
//   flag_zero/carry   status flags of the last writeback / last ADD
//   busy              high whenever not IDLE
//   div_err           only with DIV_ZERO_TRAP_EN: sticky divide-by-zero flag
// Build option: define DIV_ZERO_TRAP_EN to suppress the writeback of a DIV
// by zero (result_data forced to 8'hFF, flags held, div_err set).
// -----------------------------------------------------------------------------
module alu_exec_sequencer
    import cpu_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    alu_exec_sequencer_if.slave  instr_if,
    output logic [DATA_W-1:0]    alu_a,
    output logic [DATA_W-1:0]    alu_b,
    output logic [3:0]           alu_sel,
    input  logic [DATA_W-1:0]    alu_out,
    input  logic                 alu_carry,
    output logic                 result_valid,
    output logic [RADDR_W-1:0]   result_rd,
    output logic [DATA_W-1:0]    result_data,
    output logic                 flag_zero,
    output logic                 flag_carry,
    output logic                 busy
`ifdef DIV_ZERO_TRAP_EN
    ,
    output logic                 div_err
`endif
);

    state_e              state_q, state_d;
    logic [INSTR_W-1:0]  instr_q;
    logic [DATA_W-1:0]   alu_a_q, alu_b_q;
    logic [3:0]          alu_sel_q;
    logic                carry_hold_q;
    logic                trap_q;
    logic                result_valid_q;
    logic [RADDR_W-1:0]  result_rd_q;
    logic [DATA_W-1:0]   result_data_q;
    logic                flag_zero_q, flag_carry_q;
    logic                instr_ready_q, busy_q;

    logic                accept_s;
    logic                trap_s;
    logic                wr_en_s;
    logic [DATA_W-1:0]   rd_a_data_s, rd_b_data_s;

    // instr_ready_q is only ever high in IDLE, so this is the IDLE handshake.
    assign accept_s = instr_if.instr_valid & instr_ready_q;

`ifdef DIV_ZERO_TRAP_EN
    assign trap_s = (alu_sel_q == OP_DIV) && (alu_b_q == {DATA_W{1'b0}});
`else
    assign trap_s = 1'b0;
`endif

    assign wr_en_s = (state_q == WB) && !trap_q;

    regfile_4x8 u_regfile (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (wr_en_s),
        .waddr   (result_rd_q),
        .wdata   (result_data_q),
        .raddr_a (f_rd(instr_q)),
        .rdata_a (rd_a_data_s),
        .raddr_b (f_rs(instr_q)),
        .rdata_b (rd_b_data_s)
    );

    // Next-state logic of the four-phase execute sequence.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    state_d = DECODE;
                end else begin
                    state_d = IDLE;
                end
            end
            DECODE:  state_d = EXEC;
            EXEC:    state_d = WB;
            WB:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register and datapath registers. Status outputs are derived from
    // state_d so they are registered yet aligned with the state they describe.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            instr_q        <= {INSTR_W{1'b0}};
            alu_a_q        <= {DATA_W{1'b0}};
            alu_b_q        <= {DATA_W{1'b0}};
            alu_sel_q      <= 4'b0000;
            carry_hold_q   <= 1'b0;
            trap_q         <= 1'b0;
            result_valid_q <= 1'b0;
            result_rd_q    <= {RADDR_W{1'b0}};
            result_data_q  <= {DATA_W{1'b0}};
            flag_zero_q    <= 1'b0;
            flag_carry_q   <= 1'b0;
            instr_ready_q  <= 1'b1;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            instr_ready_q  <= (state_d == IDLE);
            busy_q         <= (state_d != IDLE);
            result_valid_q <= (state_d == WB);
            case (state_q)
                IDLE: begin
                    if (accept_s) begin
                        instr_q <= instr_if.instr;
                    end
                end
                DECODE: begin
                    alu_a_q   <= rd_a_data_s;
                    alu_b_q   <= f_imm_en(instr_q) ? f_imm_zext(instr_q) : rd_b_data_s;
                    alu_sel_q <= f_sel(instr_q);
                end
                EXEC: begin
                    // The result register doubles as the holding register, so
                    // result_data is already stable for the whole WB cycle.
                    result_data_q <= trap_s ? {DATA_W{1'b1}} : alu_out;
                    result_rd_q   <= f_rd(instr_q);
                    carry_hold_q  <= alu_carry;
                    trap_q        <= trap_s;
                end
                WB: begin
                    if (!trap_q) begin
                        flag_zero_q <= (result_data_q == {DATA_W{1'b0}});
                        if (alu_sel_q == OP_ADD) begin
                            flag_carry_q <= carry_hold_q;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef DIV_ZERO_TRAP_EN
    logic div_err_q;

    // Sticky divide-by-zero indication, cleared only by reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_err_q <= 1'b0;
        end else if ((state_q == EXEC) && trap_s) begin
            div_err_q <= 1'b1;
        end
    end

    assign div_err = div_err_q;
`endif

    assign instr_if.instr_ready = instr_ready_q;
    assign alu_a        = alu_a_q;
    assign alu_b        = alu_b_q;
    assign alu_sel      = alu_sel_q;
    assign result_valid = result_valid_q;
    assign result_rd    = result_rd_q;
    assign result_data  = result_data_q;
    assign flag_zero    = flag_zero_q;
    assign flag_carry   = flag_carry_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_alu_exec_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_exec_sequencer
// Directed bench with a small ALU model attached to the sequencer. Stimulus
// pushes the hand-computed writeback into a queue; a monitor pops and
// compares on every result_valid pulse, and also checks the handshake-to-
// result latency. Flags and register contents are checked after each op.
// ALU model opcodes: 0 ADD, 1 SUB, 3 DIV (x/0 -> FF), 5 XOR.
// -----------------------------------------------------------------------------
module tb_alu_exec_sequencer;
    import cpu_pkg::*;

    typedef struct {
        logic [1:0] rd;
        logic [7:0] data;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [7:0] alu_a, alu_b, alu_out;
    logic [3:0] alu_sel;
    logic       alu_carry;
    logic       result_valid;
    logic [1:0] result_rd;
    logic [7:0] result_data;
    logic       flag_zero, flag_carry, busy;
`ifdef DIV_ZERO_TRAP_EN
    logic       div_err;
`endif

    alu_exec_sequencer_if dif ();

    alu_exec_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .instr_if     (dif.slave),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_sel      (alu_sel),
        .alu_out      (alu_out),
        .alu_carry    (alu_carry),
        .result_valid (result_valid),
        .result_rd    (result_rd),
        .result_data  (result_data),
        .flag_zero    (flag_zero),
        .flag_carry   (flag_carry),
        .busy         (busy)
`ifdef DIV_ZERO_TRAP_EN
        ,
        .div_err      (div_err)
`endif
    );

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t exp_q[$];
    int   hs_q[$];
    int   pulse_q[$];
    exp_t mon_e;
    int   mon_hs;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural ALU
    always_comb begin
        alu_out   = 8'h00;
        alu_carry = 1'b0;
        case (alu_sel)
            4'h0:    {alu_carry, alu_out} = {1'b0, alu_a} + {1'b0, alu_b};
            4'h1:    alu_out = alu_a - alu_b;
            4'h3:    alu_out = (alu_b == 8'h00) ? 8'hFF : (alu_a / alu_b);
            4'h5:    alu_out = alu_a ^ alu_b;
            default: alu_out = 8'h00;
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] mk(input logic [3:0] sel, input logic [1:0] rd,
                                       input logic [1:0] rs, input logic ie, input logic [6:0] imm);
        return {sel, rd, rs, ie, imm};
    endfunction

    // Monitor: handshakes and writeback pulses, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n && dif.instr_valid && dif.instr_ready) hs_q.push_back(cyc);
        if (result_valid) begin
            pulse_q.push_back(cyc);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got rd=%0d data=%0h expected no pulse", result_rd, result_data);
            end else begin
                mon_e = exp_q.pop_front();
                chk("result_rd", {30'd0, result_rd}, {30'd0, mon_e.rd});
                chk("result_data", {24'd0, result_data}, {24'd0, mon_e.data});
            end
            if (hs_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL latency: got pulse at cycle %0d expected a prior handshake", cyc);
            end else begin
                mon_hs = hs_q.pop_front();
                chk("latency", cyc, mon_hs + 3);
            end
        end
    end

    // Present one instruction and hold it until accepted (bounded).
    task automatic issue(input logic [15:0] ins);
        int n;
        dif.instr_valid = 1'b1;
        dif.instr       = ins;
        n = 0;
        @(negedge clk);
        while (!dif.instr_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            checks++;
            errors++;
            $display("FAIL handshake_timeout: got instr_ready=0 expected 1 within 20 cycles");
        end
        @(posedge clk);
        #1;
        dif.instr_valid = 1'b0;
    endtask

    // Issue with an expected writeback, then wait until WB has completed.
    task automatic run(input logic [15:0] ins, input logic [1:0] rd, input logic [7:0] data);
        exp_t e;
        e.rd = rd;
        e.data = data;
        exp_q.push_back(e);
        issue(ins);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        int n0;
        logic [15:0] bp [3];
        #200000;
        $display("FAIL watchdog: got no completion expected finish before 200us");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        logic [15:0] bp [3];
        rst_n           = 1'b0;
        dif.instr_valid = 1'b0;
        dif.instr       = 16'h0000;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_alu_a", {24'd0, alu_a}, 32'd0);
        chk("rst_alu_b", {24'd0, alu_b}, 32'd0);
        chk("rst_alu_sel", {28'd0, alu_sel}, 32'd0);
        chk("rst_result_valid", {31'd0, result_valid}, 32'd0);
        chk("rst_result_rd", {30'd0, result_rd}, 32'd0);
        chk("rst_result_data", {24'd0, result_data}, 32'd0);
        chk("rst_flags", {30'd0, flag_zero, flag_carry}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_instr_ready", {31'd0, dif.instr_ready}, 32'd1);
`ifdef DIV_ZERO_TRAP_EN
        chk("rst_div_err", {31'd0, div_err}, 32'd0);
`endif
        rst_n = 1'b1;

        // All registers read 0 (ADD rX, #0 writes back the old value)
        for (int r = 0; r < 4; r++) begin
            run(mk(4'h0, r[1:0], 2'd0, 1'b1, 7'd0), r[1:0], 8'h00);
        end
        chk("zero_flag_after_reads", {31'd0, flag_zero}, 32'd1);

        // Immediate add: ADD r0, #5
        run(16'h0085, 2'd0, 8'h05);
        chk("imm_add_flag_zero", {31'd0, flag_zero}, 32'd0);
        chk("imm_add_flag_carry", {31'd0, flag_carry}, 32'd0);
        chk("imm_add_alu_a_hold", {24'd0, alu_a}, 32'd0);
        chk("imm_add_alu_b_hold", {24'd0, alu_b}, 32'd5);
        chk("imm_add_busy", {31'd0, busy}, 32'd0);

        // Build r1=200, r2=100, then ADD r1,r2 -> 44 with carry
        run(mk(4'h0, 2'd1, 2'd0, 1'b1, 7'd100), 2'd1, 8'd100);
        run(mk(4'h0, 2'd1, 2'd0, 1'b1, 7'd100), 2'd1, 8'd200);
        run(mk(4'h0, 2'd2, 2'd0, 1'b1, 7'd100), 2'd2, 8'd100);
        run(mk(4'h0, 2'd1, 2'd2, 1'b0, 7'd0), 2'd1, 8'd44);
        chk("reg_add_flag_carry", {31'd0, flag_carry}, 32'd1);
        chk("reg_add_flag_zero", {31'd0, flag_zero}, 32'd0);
        // XOR r1,r1 (rd == rs) -> 0; carry not touched by non-ADD
        run(mk(4'h5, 2'd1, 2'd1, 1'b0, 7'd0), 2'd1, 8'd0);
        chk("xor_flag_zero", {31'd0, flag_zero}, 32'd1);
        chk("xor_flag_carry_hold", {31'd0, flag_carry}, 32'd1);
        // SUB r2, #30 -> 70
        run(mk(4'h1, 2'd2, 2'd0, 1'b1, 7'd30), 2'd2, 8'd70);

        // Back-pressure: instr_valid held high across three instructions on r3
        bp[0] = mk(4'h0, 2'd3, 2'd0, 1'b1, 7'd1);
        bp[1] = mk(4'h0, 2'd3, 2'd0, 1'b1, 7'd2);
        bp[2] = mk(4'h0, 2'd3, 2'd0, 1'b1, 7'd4);
        n0 = pulse_q.size();
        begin
            exp_t e;
            e.rd = 2'd3; e.data = 8'd1; exp_q.push_back(e);
            e.rd = 2'd3; e.data = 8'd3; exp_q.push_back(e);
            e.rd = 2'd3; e.data = 8'd7; exp_q.push_back(e);
        end
        dif.instr_valid = 1'b1;
        dif.instr       = bp[0];
        for (int j = 0; j < 3; j++) begin
            int n;
            n = 0;
            @(negedge clk);
            while (!dif.instr_ready && n < 20) begin
                @(negedge clk);
                n++;
            end
            if (n >= 20) begin
                checks++;
                errors++;
                $display("FAIL bp_timeout: got instr_ready=0 expected 1 within 20 cycles");
            end
            @(posedge clk);
            #1;
            if (j < 2) dif.instr = bp[j+1];
            else dif.instr_valid = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("bp_pulse_count", pulse_q.size() - n0, 32'd3);
        if (pulse_q.size() - n0 == 3) begin
            chk("bp_spacing_1", pulse_q[n0+1] - pulse_q[n0], 32'd4);
            chk("bp_spacing_2", pulse_q[n0+2] - pulse_q[n0+1], 32'd4);
        end

        // Reset during EXEC: ADD r3, #7 must never write back
        n0 = pulse_q.size();
        issue(mk(4'h0, 2'd3, 2'd0, 1'b1, 7'd7));
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_instr_ready", {31'd0, dif.instr_ready}, 32'd1);
        chk("midrst_result_valid", {31'd0, result_valid}, 32'd0);
        hs_q.delete();
        repeat (3) @(posedge clk);
        #1;
        chk("midrst_no_pulse", pulse_q.size() - n0, 32'd0);
        run(mk(4'h0, 2'd3, 2'd0, 1'b1, 7'd0), 2'd3, 8'd0);

        // Divide: r0 = 9, DIV r0, #2 -> 4; then r0 = 9 and DIV r0, #0
        run(mk(4'h0, 2'd0, 2'd0, 1'b1, 7'd9), 2'd0, 8'd9);
        run(mk(4'h3, 2'd0, 2'd0, 1'b1, 7'd2), 2'd0, 8'd4);
        run(mk(4'h0, 2'd0, 2'd0, 1'b1, 7'd5), 2'd0, 8'd9);
        run(16'h3080, 2'd0, 8'hFF);
`ifdef DIV_ZERO_TRAP_EN
        chk("div0_err", {31'd0, div_err}, 32'd1);
        chk("div0_flag_zero_hold", {31'd0, flag_zero}, 32'd0);
        run(mk(4'h0, 2'd0, 2'd0, 1'b1, 7'd0), 2'd0, 8'd9);
        chk("div0_err_sticky", {31'd0, div_err}, 32'd1);
`else
        chk("div0_flag_zero", {31'd0, flag_zero}, 32'd0);
        run(mk(4'h0, 2'd0, 2'd0, 1'b1, 7'd0), 2'd0, 8'hFF);
`endif

        repeat (2) @(posedge clk);
        #1;
        chk("scoreboard_drained", exp_q.size(), 32'd0);
        chk("handshakes_drained", hs_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
